// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: turns the raw byte stream from the PS/2 receiver into
// make/break key events (with E0-extended flag), tracks the four arrow keys and
// emits a one-cycle direction strobe on each arrow press.
//
// Build option: define PS2_TYPEMATIC_FILTER_EN to suppress dir_valid on
// typematic repeats of an arrow key that is already held.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  UP_CODE        = 8'h75,
    parameter logic [7:0]  DOWN_CODE      = 8'h72,
    parameter logic [7:0]  LEFT_CODE      = 8'h6B,
    parameter logic [7:0]  RIGHT_CODE     = 8'h74
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_break,
    output logic [3:0] arrow_held,
    output logic       dir_valid,
    output logic [1:0] dir,
    output logic       seq_error
);

    localparam int unsigned   CntW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] TimeoutMax = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] PrefixExt = 8'hE0;
    localparam logic [7:0] PrefixBrk = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            byte_discard;
    logic            byte_accept;
    logic            emit;
    logic            emit_ext;
    logic            emit_brk;
    logic            err;

    logic            dir_hit;
    logic [1:0]      dir_idx;
    logic [3:0]      dir_mask;
    logic            is_arrow;
    logic            dir_fire;

    logic            key_valid_q, key_valid_d;
    logic [7:0]      key_code_q, key_code_d;
    logic            key_ext_q, key_ext_d;
    logic            key_brk_q, key_brk_d;
    logic [3:0]      arrow_q, arrow_d;
    logic            dir_valid_q, dir_valid_d;
    logic [1:0]      dir_q, dir_d;
    logic            seq_err_q, seq_err_d;

    // Controller status / ack / BAT bytes carry no key information.
    always_comb begin
        byte_discard = 1'b0;
        case (rx_data)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: byte_discard = 1'b1;
            default: byte_discard = 1'b0;
        endcase
    end

    assign byte_accept = rx_valid & ~byte_discard;

    // Prefix FSM next state, timeout counter and event/error decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        err      = 1'b0;

        if (byte_accept) begin
            // An accepted byte always wins over a coincident timeout.
            cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (rx_data == PrefixExt) begin
                        state_d = StExt;
                    end else if (rx_data == PrefixBrk) begin
                        state_d = StBrk;
                    end else begin
                        emit = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_data == PrefixExt) begin
                        err     = 1'b1;
                        state_d = StExt;
                    end else if (rx_data == PrefixBrk) begin
                        state_d = StExtBrk;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    // A repeated prefix restarts the sequence as if seen from idle.
                    if (rx_data == PrefixExt) begin
                        err     = 1'b1;
                        state_d = StExt;
                    end else if (rx_data == PrefixBrk) begin
                        err     = 1'b1;
                        state_d = StBrk;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = (state_q == StExtBrk);
                        emit_brk = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (cnt_q == TimeoutMax) begin
                err     = 1'b1;
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Prefix FSM state and timeout counter registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Map the current byte onto an arrow index (only meaningful for extended codes).
    always_comb begin
        dir_hit = 1'b1;
        dir_idx = 2'd0;
        if (rx_data == UP_CODE) begin
            dir_idx = 2'd0;
        end else if (rx_data == DOWN_CODE) begin
            dir_idx = 2'd1;
        end else if (rx_data == LEFT_CODE) begin
            dir_idx = 2'd2;
        end else if (rx_data == RIGHT_CODE) begin
            dir_idx = 2'd3;
        end else begin
            dir_hit = 1'b0;
        end
    end

    assign dir_mask = 4'b0001 << dir_idx;
    assign is_arrow = emit & emit_ext & dir_hit;

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Auto-repeat of an already-held arrow must not re-trigger a move.
    assign dir_fire = is_arrow & ~emit_brk & ~|(arrow_q & dir_mask);
`else
    assign dir_fire = is_arrow & ~emit_brk;
`endif

    // Next values of the registered event outputs.
    always_comb begin
        key_valid_d = emit;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_brk_d   = key_brk_q;
        arrow_d     = arrow_q;
        dir_valid_d = dir_fire;
        dir_d       = dir_q;
        seq_err_d   = err;

        if (emit) begin
            key_code_d = rx_data;
            key_ext_d  = emit_ext;
            key_brk_d  = emit_brk;
        end
        if (is_arrow) begin
            arrow_d = emit_brk ? (arrow_q & ~dir_mask) : (arrow_q | dir_mask);
        end
        if (dir_fire) begin
            dir_d = dir_idx;
        end
    end

    // Output registers; all outputs clear on reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_brk_q   <= 1'b0;
            arrow_q     <= 4'b0000;
            dir_valid_q <= 1'b0;
            dir_q       <= 2'b00;
            seq_err_q   <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_brk_q   <= key_brk_d;
            arrow_q     <= arrow_d;
            dir_valid_q <= dir_valid_d;
            dir_q       <= dir_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_extended = key_ext_q;
    assign key_break    = key_brk_q;
    assign arrow_held   = arrow_q;
    assign dir_valid    = dir_valid_q;
    assign dir          = dir_q;
    assign seq_error    = seq_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed byte sequences push the
// expected events; a monitor pops and compares whenever the DUT emits.
module tb_ps2_scancode_decoder;

    localparam int unsigned TMO = 200;

    logic       clk;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_break;
    logic [3:0] arrow_held;
    logic       dir_valid;
    logic [1:0] dir;
    logic       seq_error;

    ps2_scancode_decoder #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_extended(key_extended),
        .key_break   (key_break),
        .arrow_held  (arrow_held),
        .dir_valid   (dir_valid),
        .dir         (dir),
        .seq_error   (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       dv;
        logic [1:0] dir;
        logic [3:0] held;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic exp_key(input logic [7:0] code, input logic ext, input logic brk,
                           input logic dv, input logic [1:0] d, input logic [3:0] held);
        exp_t e;
        e.err  = 1'b0;
        e.code = code;
        e.ext  = ext;
        e.brk  = brk;
        e.dv   = dv;
        e.dir  = d;
        e.held = held;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e = '0;
        e.err = 1'b1;
        exp_q.push_back(e);
    endtask

    // Drive one byte for one cycle, then leave a gap so the event is seen.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key_valid"}, key_valid, 0);
        chk({tag, "_key_code"}, key_code, 0);
        chk({tag, "_key_extended"}, key_extended, 0);
        chk({tag, "_key_break"}, key_break, 0);
        chk({tag, "_arrow_held"}, arrow_held, 0);
        chk({tag, "_dir_valid"}, dir_valid, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_seq_error"}, seq_error, 0);
    endtask

    // Monitor: any output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (resetn && (key_valid || seq_error || dir_valid)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got kv=%0b err=%0b dv=%0b code=%0h want none",
                         key_valid, seq_error, dir_valid, key_code);
            end else begin
                mon_e = exp_q.pop_front();
                chk("seq_error", seq_error, mon_e.err);
                chk("key_valid", key_valid, !mon_e.err);
                if (!mon_e.err) begin
                    chk("key_code", key_code, mon_e.code);
                    chk("key_extended", key_extended, mon_e.ext);
                    chk("key_break", key_break, mon_e.brk);
                    chk("dir_valid", dir_valid, mon_e.dv);
                    chk("arrow_held", arrow_held, mon_e.held);
                    if (mon_e.dv) chk("dir", dir, mon_e.dir);
                end
            end
        end
    end

    initial begin
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Up make then break.
        exp_key(8'h75, 1, 0, 1, 2'b00, 4'b0001);
        send(8'hE0); send(8'h75);
        exp_key(8'h75, 1, 1, 0, 2'b00, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Plain key, discarded byte, left make.
        exp_key(8'h1C, 0, 0, 0, 2'b00, 4'b0000);
        send(8'h1C);
        send(8'hAA);
        exp_key(8'h6B, 1, 0, 1, 2'b10, 4'b0100);
        send(8'hE0); send(8'h6B);

        // Timeout after a lone prefix, then 75 is a plain make.
        exp_err();
        send(8'hE0);
        repeat (TMO + 50) @(posedge clk);
        #1;
        exp_key(8'h75, 0, 0, 0, 2'b00, 4'b0100);
        send(8'h75);

        // Long but legal gap inside a prefix: no early timeout.
        exp_key(8'h75, 1, 0, 1, 2'b00, 4'b0101);
        send(8'hE0);
        repeat (TMO - 60) @(posedge clk);
        #1;
        send(8'h75);

        // Prefix restarts.
        exp_err();
        exp_key(8'h72, 1, 0, 1, 2'b01, 4'b0111);
        send(8'hE0); send(8'hE0); send(8'h72);
        exp_err();
        exp_key(8'h1C, 0, 1, 0, 2'b00, 4'b0111);
        send(8'hF0); send(8'hF0); send(8'h1C);
        exp_key(8'h72, 1, 1, 0, 2'b00, 4'b0101);
        send(8'hE0); send(8'hF0); send(8'h72);

        // Typematic repeat of right.
        exp_key(8'h74, 1, 0, 1, 2'b11, 4'b1101);
        send(8'hE0); send(8'h74);
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_key(8'h74, 1, 0, 0, 2'b11, 4'b1101);
`else
        exp_key(8'h74, 1, 0, 1, 2'b11, 4'b1101);
`endif
        send(8'hE0); send(8'h74);

        // Reset in the middle of a prefix discards it.
        send(8'hE0); send(8'hF0);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("midreset");
        resetn = 1'b1;
        @(posedge clk);
        #1;
        exp_key(8'h6B, 0, 0, 0, 2'b00, 4'b0000);
        send(8'h6B);

        repeat (10) @(posedge clk);
        #1;
        chk("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
